trk_disc: RTL and testbench
===========================

# trk_disc

Tracking-loop discriminator stage for the B1 channel, sitting between the correlator integrate-and-dump and the DLL/PLL loop filter. Once per PRN period it takes the dumped early/prompt/late I/Q accumulations, computes a normalised early-minus-late power DLL discriminator and a normalised Costas PLL discriminator through one shared sequential divider, and presents both as signed 32-bit words with a one-cycle `tx_prn_sop` strobe that drives the loop filter's `rx_prn_sop`.

## Interface
- `ACC_W`, 24, width of each signed I/Q accumulation input
- `FRAC`, 30, fractional bits of the discriminator outputs (unity = 2^FRAC)

Ports:
- `rx_clk`  in  1  single clock
- `rx_rst`  in  1  reset, synchronous, active-high
- `rx_acc_valid`  in  1  one-cycle pulse: accumulations valid
- `rx_ie`, `rx_qe`, `rx_ip`, `rx_qp`, `rx_il`, `rx_ql`  in  ACC_W each  signed early/prompt/late I/Q
- `tx_dll_disc`  out  32  signed DLL discriminator, Q1.FRAC
- `tx_pll_disc`  out  32  signed PLL discriminator, Q1.FRAC
- `tx_prn_sop`  out  1  one-cycle strobe: new discriminator values
- `tx_busy`  out  1  high in every state except IDLE
- `tx_drop`  out  1  sticky: an `rx_acc_valid` was discarded

## Operation
- The FSM has states IDLE, MUL, SUM, DIV_DLL, DIV_PLL and DONE.
- **Capture:** `rx_acc_valid` is accepted only in IDLE or DONE. It registers all six inputs and moves the FSM to MUL. A valid in any other state is ignored and sets `tx_drop`.
- **MUL:** register E2 = IE²+QE² and L2 = IL²+QL², each unsigned 2·ACC_W+1 bits. Also register sign(IP) and |IP|, |QP| at ACC_W+1 bits, so that -2^(ACC_W-1) is handled.
- **SUM:**
  - DLL terms: numerator n_d = E2−L2 (signed), denominator d_d = E2+L2.
  - PLL terms: n_p = QP·sign(IP), where sign(0) = +1, and d_p = |IP|+|QP|.
- **DIV_DLL, then DIV_PLL:** each step is an unsigned restoring division of |n|·2^FRAC by d, taking exactly FRAC+1 iterations at one quotient bit per cycle. The quotient is truncated toward zero, then the sign of n is applied.
  - The result range is [−2^FRAC, +2^FRAC] and fits in 32 bits.
  - If d = 0, the result is 0. The iteration count is unchanged.
- **DONE:** `tx_dll_disc` and `tx_pll_disc` update, and `tx_prn_sop` = 1 for this cycle only. The FSM then goes to IDLE, or to MUL if a valid was accepted this cycle.
- `tx_dll_disc` and `tx_pll_disc` hold their values until the next DONE. The loop filter samples them both in the strobe cycle and in the cycle after it.
- `tx_drop` clears only on reset.

## Timing
- Reset values: `tx_dll_disc` = 0, `tx_pll_disc` = 0, `tx_prn_sop` = 0, `tx_busy` = 0, `tx_drop` = 0, FSM in IDLE. All internal registers are cleared.
- Latency: with `rx_acc_valid` in cycle N, `tx_prn_sop` is high in cycle N+2·(FRAC+1)+3, which is N+65 for the defaults. The latency is fixed and independent of the data.
- `tx_busy` is high from N+1 through N+65 inclusive.
- Minimum accepted valid spacing is 65 cycles. A valid arriving in the DONE cycle is accepted with no bubble.
- Reset mid-operation aborts the computation. No strobe is issued and the outputs return to 0.
- Reset and `rx_acc_valid` in the same cycle: reset wins and the valid is discarded without setting `tx_drop`.

## Structure
- Package `trk_pkg` holds:
  - the FSM state enum;
  - the `FRAC` and `ACC_W` defaults;
  - the derived widths POW_W = 2·ACC_W+1 and DIV_W = POW_W+FRAC.
- Sub-module `trk_div_seq` is a parameterised unsigned restoring divider with `start`/`done` and a fixed FRAC+1 iteration count. It is instantiated once and shared between the DLL and PLL divisions.
- Multipliers are inferred as registered products in MUL.

## Test plan
1. IE=1000, QE=0, IL=QL=0, IP=1000, QP=0 -> DLL = 0x40000000, PLL = 0, strobe exactly at N+65.
2. IE=300, QE=400, IL=500, QL=0, IP=−600, QP=200 -> DLL = 0, PLL = −268435456 (0xF0000000).
3. All inputs zero -> both outputs 0, no error, strobe still at N+65.
4. IE=3, QE=0, IL=1, QL=0, IP=QP=−2^23 -> DLL = 858993459, PLL = 0x20000000.
5. Valids at N, N+10 and N+65 -> the one at N+10 is dropped and `tx_drop` = 1; strobes at N+65 and N+130.
6. Reset asserted at N+40 -> no strobe and outputs 0. A new valid after reset is processed normally with 65-cycle latency.

Source files
------------

// File: rtl/trk_pkg.sv
// Shared types and default widths for the B1 tracking-loop discriminator.
package trk_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int FRAC_DEF  = 30;

    // E2/L2 power width and the scaled-dividend width seen by the divider.
    localparam int POW_W = 2 * ACC_W_DEF + 1;
    localparam int DIV_W = POW_W + FRAC_DEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_SUM     = 3'd2,
        ST_DIV_DLL = 3'd3,
        ST_DIV_PLL = 3'd4,
        ST_DONE    = 3'd5
    } trk_state_t;

endpackage

// File: rtl/trk_div_seq.sv
// Unsigned restoring divider: quo = (num * 2^FRAC) / den, valid only for num <= den.
// Always FRAC+1 iterations; the first one is folded into the start cycle.
module trk_div_seq #(
    parameter int NUM_W = 49,
    parameter int FRAC  = 30
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [NUM_W-1:0] den,
    output logic             done,
    output logic [FRAC:0]    quo
);

    localparam int DIV_W = NUM_W + FRAC;
    localparam int CNT_W = $clog2(FRAC + 1);

    logic [NUM_W-1:0] rem_reg;
    logic [NUM_W-1:0] den_reg;
    logic [FRAC:0]    dvd_reg;
    logic [FRAC:0]    quo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             run_reg;
    logic             done_reg;
    logic             zero_reg;

    logic [DIV_W-1:0] scaled;
    logic [NUM_W-1:0] rem_cur;
    logic [NUM_W-1:0] den_cur;
    logic [FRAC:0]    dvd_cur;
    logic [NUM_W:0]   trial;
    logic             fit;
    logic [NUM_W-1:0] rem_next;

    // Since num <= den, every quotient bit above 2^FRAC is zero, so the
    // partial remainder can be preloaded with the top NUM_W-1 dividend bits.
    always_comb begin
        scaled = {num, {FRAC{1'b0}}};
        if (start) begin
            rem_cur = {1'b0, scaled[DIV_W-1:FRAC+1]};
            dvd_cur = scaled[FRAC:0];
            den_cur = den;
        end else begin
            rem_cur = rem_reg;
            dvd_cur = dvd_reg;
            den_cur = den_reg;
        end
        trial    = {rem_cur, dvd_cur[FRAC]};
        fit      = (trial >= {1'b0, den_cur});
        rem_next = fit ? NUM_W'(trial - {1'b0, den_cur}) : trial[NUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rem_reg  <= '0;
            den_reg  <= '0;
            dvd_reg  <= '0;
            quo_reg  <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg  <= rem_next;
                den_reg  <= den;
                dvd_reg  <= {dvd_cur[FRAC-1:0], 1'b0};
                quo_reg  <= {{FRAC{1'b0}}, fit};
                cnt_reg  <= CNT_W'(FRAC);
                run_reg  <= 1'b1;
                zero_reg <= (den == '0);
            end else if (run_reg) begin
                rem_reg <= rem_next;
                dvd_reg <= {dvd_cur[FRAC-1:0], 1'b0};
                quo_reg <= {quo_reg[FRAC-1:0], fit};
                cnt_reg <= cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign quo  = zero_reg ? '0 : quo_reg;

endmodule

// File: rtl/trk_disc.sv
// Early-minus-late power DLL and Costas PLL discriminators, normalised
// through one shared sequential divider; fixed latency of 2*(FRAC+1)+3 cycles.
module trk_disc
    import trk_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                    rx_clk,
    input  logic                    rx_rst,
    input  logic                    rx_acc_valid,
    input  logic signed [ACC_W-1:0] rx_ie,
    input  logic signed [ACC_W-1:0] rx_qe,
    input  logic signed [ACC_W-1:0] rx_ip,
    input  logic signed [ACC_W-1:0] rx_qp,
    input  logic signed [ACC_W-1:0] rx_il,
    input  logic signed [ACC_W-1:0] rx_ql,
    output logic signed [31:0]      tx_dll_disc,
    output logic signed [31:0]      tx_pll_disc,
    output logic                    tx_prn_sop,
    output logic                    tx_busy,
    output logic                    tx_drop
);

    localparam int PW = 2 * ACC_W + 1;

    trk_state_t state_reg;

    logic signed [ACC_W-1:0] ie_reg, qe_reg, ip_reg, qp_reg, il_reg, ql_reg;
    logic [PW-1:0]    e2_reg, l2_reg;
    logic [ACC_W:0]   ip_abs_reg, qp_abs_reg;
    logic             ip_neg_reg, qp_neg_reg;
    logic             neg_d_reg, neg_p_reg;
    logic [ACC_W:0]   num_p_reg;
    logic [ACC_W+1:0] den_p_reg;
    logic signed [31:0] dll_res_reg;
    logic signed [31:0] dll_out_reg, pll_out_reg;
    logic             sop_reg, busy_reg, drop_reg;

    logic                    accept;
    logic signed [2*ACC_W-1:0] sq_ie, sq_qe, sq_il, sq_ql;
    logic [PW-1:0]           e2_next, l2_next;
    logic [ACC_W:0]          ipx, qpx;
    logic [PW-1:0]           div_num, div_den;
    logic                    div_start, div_done;
    logic [FRAC:0]           div_quo;

    function automatic logic signed [31:0] apply_sign(input logic neg, input logic [FRAC:0] mag);
        logic signed [31:0] m;
        m = 32'(mag);
        return neg ? -m : m;
    endfunction

    always_comb begin
        accept  = rx_acc_valid && (state_reg == ST_IDLE || state_reg == ST_DONE);
        sq_ie   = ie_reg * ie_reg;
        sq_qe   = qe_reg * qe_reg;
        sq_il   = il_reg * il_reg;
        sq_ql   = ql_reg * ql_reg;
        e2_next = {1'b0, sq_ie} + {1'b0, sq_qe};
        l2_next = {1'b0, sq_il} + {1'b0, sq_ql};
        // One extra bit so that |-2^(ACC_W-1)| is representable.
        ipx     = {ip_reg[ACC_W-1], ip_reg};
        qpx     = {qp_reg[ACC_W-1], qp_reg};
    end

    // The DLL division is launched straight from the SUM terms; the PLL one
    // starts in the cycle the DLL quotient comes back.
    always_comb begin
        div_start = (state_reg == ST_SUM) || (state_reg == ST_DIV_DLL && div_done);
        if (state_reg == ST_SUM) begin
            div_num = (e2_reg < l2_reg) ? (l2_reg - e2_reg) : (e2_reg - l2_reg);
            div_den = e2_reg + l2_reg;
        end else begin
            div_num = PW'(num_p_reg);
            div_den = PW'(den_p_reg);
        end
    end

    trk_div_seq #(
        .NUM_W (PW),
        .FRAC  (FRAC)
    ) u_div (
        .clk   (rx_clk),
        .srst  (rx_rst),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quo   (div_quo)
    );

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_reg   <= ST_IDLE;
            ie_reg      <= '0;
            qe_reg      <= '0;
            ip_reg      <= '0;
            qp_reg      <= '0;
            il_reg      <= '0;
            ql_reg      <= '0;
            e2_reg      <= '0;
            l2_reg      <= '0;
            ip_abs_reg  <= '0;
            qp_abs_reg  <= '0;
            ip_neg_reg  <= 1'b0;
            qp_neg_reg  <= 1'b0;
            neg_d_reg   <= 1'b0;
            neg_p_reg   <= 1'b0;
            num_p_reg   <= '0;
            den_p_reg   <= '0;
            dll_res_reg <= '0;
            dll_out_reg <= '0;
            pll_out_reg <= '0;
            sop_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            sop_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= ST_MUL;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    e2_reg     <= e2_next;
                    l2_reg     <= l2_next;
                    ip_abs_reg <= ipx[ACC_W] ? -ipx : ipx;
                    qp_abs_reg <= qpx[ACC_W] ? -qpx : qpx;
                    ip_neg_reg <= ip_reg[ACC_W-1];
                    qp_neg_reg <= qp_reg[ACC_W-1];
                    state_reg  <= ST_SUM;
                end
                ST_SUM: begin
                    neg_d_reg <= (e2_reg < l2_reg);
                    neg_p_reg <= ip_neg_reg ^ qp_neg_reg;
                    num_p_reg <= qp_abs_reg;
                    den_p_reg <= (ACC_W+2)'(ip_abs_reg) + (ACC_W+2)'(qp_abs_reg);
                    state_reg <= ST_DIV_DLL;
                end
                ST_DIV_DLL: begin
                    if (div_done) begin
                        dll_res_reg <= apply_sign(neg_d_reg, div_quo);
                        state_reg   <= ST_DIV_PLL;
                    end
                end
                ST_DIV_PLL: begin
                    if (div_done) begin
                        dll_out_reg <= dll_res_reg;
                        pll_out_reg <= apply_sign(neg_p_reg, div_quo);
                        sop_reg     <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        state_reg <= ST_MUL;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            if (accept) begin
                ie_reg <= rx_ie;
                qe_reg <= rx_qe;
                ip_reg <= rx_ip;
                qp_reg <= rx_qp;
                il_reg <= rx_il;
                ql_reg <= rx_ql;
            end
            if (rx_acc_valid && !accept) begin
                drop_reg <= 1'b1;
            end
        end
    end

    assign tx_dll_disc = dll_out_reg;
    assign tx_pll_disc = pll_out_reg;
    assign tx_prn_sop  = sop_reg;
    assign tx_busy     = busy_reg;
    assign tx_drop     = drop_reg;

endmodule

// File: tb/tb_trk_disc.sv
// Directed-vector bench for trk_disc: values, 65-cycle latency, drop and reset behaviour.
module tb_trk_disc;

    localparam int ACC_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic signed [ACC_W-1:0] ie = '0, qe = '0, ip = '0, qp = '0, il = '0, ql = '0;
    logic signed [31:0] dll, pll;
    logic sop, busy, drop;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    trk_disc dut (
        .rx_clk       (clk),
        .rx_rst       (rst),
        .rx_acc_valid (valid),
        .rx_ie        (ie),
        .rx_qe        (qe),
        .rx_ip        (ip),
        .rx_qp        (qp),
        .rx_il        (il),
        .rx_ql        (ql),
        .tx_dll_disc  (dll),
        .tx_pll_disc  (pll),
        .tx_prn_sop   (sop),
        .tx_busy      (busy),
        .tx_drop      (drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h (%0d) expected=0x%08h (%0d)", tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    task automatic set_acc(input int v_ie, v_qe, v_ip, v_qp, v_il, v_ql);
        ie = 24'(v_ie);
        qe = 24'(v_qe);
        ip = 24'(v_ip);
        qp = 24'(v_qp);
        il = 24'(v_il);
        ql = 24'(v_ql);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input int v_ie, v_qe, v_ip, v_qp, v_il, v_ql,
                           input logic [31:0] exp_dll, input logic [31:0] exp_pll);
        int n;
        @(negedge clk);
        set_acc(v_ie, v_qe, v_ip, v_qp, v_il, v_ql);
        valid = 1'b1;
        n = cyc;
        @(negedge clk);
        valid = 1'b0;
        chk({tag, "_busy_n1"}, 32'(busy), 32'd1);
        while (!sop && (cyc - n) < 200) @(negedge clk);
        chk({tag, "_latency"}, 32'(cyc - n), 32'd65);
        chk({tag, "_dll"}, dll, exp_dll);
        chk({tag, "_pll"}, pll, exp_pll);
        chk({tag, "_busy_n65"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_sop_n66"}, 32'(sop), 32'd0);
        chk({tag, "_busy_n66"}, 32'(busy), 32'd0);
        chk({tag, "_dll_hold"}, dll, exp_dll);
        $display("[TB] %s dll=%0d pll=%0d latency=%0d", tag, dll, pll, cyc - 1 - n);
    endtask

    initial begin
        int n;
        int sop_seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dll", dll, 32'd0);
        chk("rst_pll", pll, 32'd0);
        chk("rst_sop", 32'(sop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);

        run_vec("t1_unit", 1000, 0, 1000, 0, 0, 0, 32'h4000_0000, 32'd0);
        run_vec("t2_quarter", 300, 400, -600, 200, 500, 0, 32'd0, 32'hF000_0000);
        run_vec("t3_zero", 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        run_vec("t4_minneg", 3, 0, -8388608, -8388608, 1, 0, 32'd858993459, 32'h2000_0000);

        // Reset together with a valid: valid discarded, no drop, outputs cleared.
        @(negedge clk);
        set_acc(1000, 0, 1000, 0, 0, 0);
        rst = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
        chk("rstv_busy", 32'(busy), 32'd0);
        chk("rstv_drop", 32'(drop), 32'd0);
        chk("rstv_dll", dll, 32'd0);
        $display("[TB] rst+valid busy=%0b drop=%0b", busy, drop);

        // Back-to-back: N accepted, N+10 dropped, N+65 accepted with no bubble.
        @(negedge clk);
        set_acc(1000, 0, 1000, 0, 0, 0);
        valid = 1'b1;
        n = cyc;
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(n + 10);
        set_acc(0, 0, 0, 0, 0, 0);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("t5_drop", 32'(drop), 32'd1);
        wait_cyc(n + 64);
        chk("t5_sop_n64", 32'(sop), 32'd0);
        wait_cyc(n + 65);
        chk("t5_sop_n65", 32'(sop), 32'd1);
        chk("t5_dll_1", dll, 32'h4000_0000);
        set_acc(300, 400, -600, 200, 500, 0);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("t5_busy_n66", 32'(busy), 32'd1);
        wait_cyc(n + 129);
        chk("t5_sop_n129", 32'(sop), 32'd0);
        wait_cyc(n + 130);
        chk("t5_sop_n130", 32'(sop), 32'd1);
        chk("t5_dll_2", dll, 32'd0);
        chk("t5_pll_2", pll, 32'hF000_0000);
        chk("t5_drop_sticky", 32'(drop), 32'd1);
        $display("[TB] t5 back-to-back drop=%0b dll=%0d pll=%0d", drop, dll, pll);

        // Reset mid-computation aborts with no strobe.
        @(negedge clk);
        set_acc(3, 0, -8388608, -8388608, 1, 0);
        valid = 1'b1;
        n = cyc;
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(n + 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sop_seen = 0;
        for (int k = 0; k < 70; k++) begin
            if (sop) sop_seen++;
            @(negedge clk);
        end
        chk("t6_no_sop", 32'(sop_seen), 32'd0);
        chk("t6_dll", dll, 32'd0);
        chk("t6_pll", pll, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_drop", 32'(drop), 32'd0);
        $display("[TB] t6 reset abort strobes=%0d dll=%0d pll=%0d", sop_seen, dll, pll);
        run_vec("t6_after", 3, 0, -8388608, -8388608, 1, 0, 32'd858993459, 32'h2000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
